cd_spi_bridge: RTL and testbench

CD_SPI_BRIDGE -- requirements
Module: cd_spi_bridge

---
 rtl/cd_spi_bridge_if.sv | 18 +
 rtl/cd_spi_bridge.sv | 194 +++++++++++++++++++
 tb/tb_cd_spi_bridge.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cd_spi_bridge_if.sv
// CSR bus between the SPI bridge (master) and the cdbus CSR block (slave).
interface cd_spi_bridge_if;
   logic [3:0]  csr_address;
   logic        csr_read;
   logic [31:0] csr_readdata;
   logic        csr_write;
   logic [31:0] csr_writedata;

   modport master (
      output csr_address, csr_read, csr_write, csr_writedata,
      input  csr_readdata
   );

   modport slave (
      input  csr_address, csr_read, csr_write, csr_writedata,
      output csr_readdata
   );
endinterface

// File: rtl/cd_spi_bridge.sv
// SPI mode-0 slave bridging command/data frames onto the cdbus CSR bus.
// All SPI pins are oversampled in the clk domain.
//
// state   | meaning
// IDLE    | no frame, or waiting for a fresh ss_n fall after reset
// CMD     | shifting in command byte, shifting out status byte
// RD_REQ  | csr_read strobe for the current address
// RD_CAP  | capture csr_readdata into the read word
// DATA    | shifting data bytes in (write) or out (read)
module cd_spi_bridge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             spi_ss_n,
   input  logic             spi_sclk,
   input  logic             spi_mosi,
   output logic             spi_miso,
   output logic             spi_miso_oe,
   input  logic             irq,
   cd_spi_bridge_if.master  csr
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CMD, ST_RD_REQ, ST_RD_CAP, ST_DATA
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
   logic       ss_s, sclk_s, mosi_s, ss_d, sclk_d;
   logic [2:0] start_cnt;
   logic       armed;
   logic       ss_fall, sclk_rise, sclk_fall, byte_end;

   logic [2:0]       bit_cnt;
   logic [1:0]       byte_cnt;
   logic [6:0]       rx_sr;
   logic [7:0]       rx_byte, tx_sr;
   logic [2:0][7:0]  wbuf;
   logic [3:0][7:0]  rd_word;
   logic             byte_done, need_read, wr_cmd, auto_inc;
   logic             read_strobe, write_q;
   logic [3:0]       addr_q;
   logic [31:0]      wdata_q;

   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // A fall only counts once the synchronizers hold a genuinely observed high level.
   assign ss_fall   = armed & ss_d & ~ss_s;
   assign sclk_rise = ~ss_s & sclk_s & ~sclk_d;
   assign sclk_fall = ~ss_s & ~sclk_s & sclk_d;
   assign byte_end  = sclk_rise && (bit_cnt == 3'd0);
   assign rx_byte   = {rx_sr, mosi_s};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         ss_d      <= 1'b1;
         sclk_d    <= 1'b0;
         start_cnt <= 3'(SYNC_STAGES);
         armed     <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         ss_d      <= ss_s;
         sclk_d    <= sclk_s;
         if (start_cnt != 3'd0) start_cnt <= start_cnt - 3'd1;
         else if (ss_s)         armed     <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      read_strobe = 1'b0;
      case (state_q)
         ST_IDLE:   if (ss_fall) state_d = ST_CMD;
         ST_CMD:    if (byte_end) state_d = rx_byte[7] ? ST_DATA : ST_RD_REQ;
         ST_RD_REQ: begin
            read_strobe = 1'b1;
            state_d     = ST_RD_CAP;
         end
         ST_RD_CAP: state_d = ST_DATA;
         // Next read word is fetched on the fall after a word's last bit, so a
         // frame that ends with sclk still high issues no trailing read.
         ST_DATA:   if (sclk_fall && byte_done && need_read) state_d = ST_RD_REQ;
         default:   state_d = ST_IDLE;
      endcase
      if (ss_s) begin
         state_d     = ST_IDLE;
         read_strobe = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt   <= 3'd7;
         byte_cnt  <= 2'd0;
         rx_sr     <= '0;
         tx_sr     <= '0;
         wbuf      <= '0;
         rd_word   <= '0;
         byte_done <= 1'b0;
         need_read <= 1'b0;
         wr_cmd    <= 1'b0;
         auto_inc  <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         write_q <= 1'b0;
         if (write_q && auto_inc) addr_q <= addr_q + 4'd1;

         if (ss_s) begin
            bit_cnt   <= 3'd7;
            byte_cnt  <= 2'd0;
            byte_done <= 1'b0;
            need_read <= 1'b0;
            tx_sr     <= '0;
         end else if (state_q == ST_IDLE) begin
            if (ss_fall) begin
               bit_cnt   <= 3'd7;
               byte_cnt  <= 2'd0;
               byte_done <= 1'b0;
               need_read <= 1'b0;
               tx_sr     <= {irq, 7'b0};
            end
         end else begin
            if (sclk_rise) begin
               rx_sr   <= rx_byte[6:0];
               bit_cnt <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
            end
            if (byte_end) begin
               byte_done <= 1'b1;
               if (state_q == ST_CMD) begin
                  wr_cmd   <= rx_byte[7];
                  auto_inc <= rx_byte[6];
                  addr_q   <= rx_byte[3:0];
               end else if (state_q == ST_DATA) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (wr_cmd) begin
                     case (byte_cnt)
                        2'd0:    wbuf[0] <= rx_byte;
                        2'd1:    wbuf[1] <= rx_byte;
                        2'd2:    wbuf[2] <= rx_byte;
                        default: begin
                           wdata_q <= {rx_byte, wbuf[2], wbuf[1], wbuf[0]};
                           write_q <= 1'b1;
                        end
                     endcase
                  end else if (byte_cnt == 2'd3) begin
                     need_read <= 1'b1;
                     if (auto_inc) addr_q <= addr_q + 4'd1;
                  end
               end
            end
            if (sclk_fall) begin
               if (byte_done && !need_read) begin
                  byte_done <= 1'b0;
                  tx_sr     <= wr_cmd ? 8'h00 : rd_word[byte_cnt];
               end else if (!byte_done) begin
                  tx_sr <= {tx_sr[6:0], 1'b0};
               end
            end
            if (state_q == ST_RD_CAP) begin
               rd_word <= csr.csr_readdata;
               if (need_read) begin
                  tx_sr     <= csr.csr_readdata[7:0];
                  need_read <= 1'b0;
                  byte_done <= 1'b0;
               end
            end
         end
      end
   end

   assign spi_miso          = tx_sr[7];
   assign spi_miso_oe       = (state_q != ST_IDLE);
   assign csr.csr_read      = read_strobe;
   assign csr.csr_write     = write_q;
   assign csr.csr_address   = addr_q;
   assign csr.csr_writedata = wdata_q;

endmodule

// File: tb/tb_cd_spi_bridge.sv
// Scoreboard bench for cd_spi_bridge: directed SPI frames, CSR strobes and MISO bytes
// checked by a monitor against queued expectations.
module tb_cd_spi_bridge;

   localparam int HALF = 100;

   typedef struct {
      logic [3:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n, spi_ss_n, spi_sclk, spi_mosi, irq;
   logic spi_miso, spi_miso_oe;

   cd_spi_bridge_if bus ();

   cd_spi_bridge #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_ss_n    (spi_ss_n),
      .spi_sclk    (spi_sclk),
      .spi_mosi    (spi_mosi),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .irq         (irq),
      .csr         (bus.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   wr_t         exp_wr_q[$];
   logic [3:0]  exp_rd_q[$];
   logic [31:0] rd_supply_q[$];
   logic [7:0]  exp_miso_q[$];
   logic [7:0]  got_miso_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%h want=%h", name, got, want);
   endtask

   // Monitor: CSR strobes and completed MISO bytes against the expectation queues.
   always @(negedge clk) begin
      wr_t        e;
      logic [3:0] ra;
      if (bus.csr_read && bus.csr_write) begin
         n_checks++;
         $display("FAIL rd_wr_same_clk got=both want=one");
      end
      if (bus.csr_write) begin
         if (exp_wr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write got addr=%h data=%h want=none", bus.csr_address, bus.csr_writedata);
         end else begin
            e = exp_wr_q.pop_front();
            check("wr_addr", {28'b0, bus.csr_address}, {28'b0, e.addr});
            check("wr_data", bus.csr_writedata, e.data);
         end
      end
      if (bus.csr_read) begin
         if (exp_rd_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_read got addr=%h want=none", bus.csr_address);
         end else begin
            ra = exp_rd_q.pop_front();
            check("rd_addr", {28'b0, bus.csr_address}, {28'b0, ra});
         end
         if (rd_supply_q.size() != 0) bus.csr_readdata = rd_supply_q.pop_front();
      end
      if (got_miso_q.size() != 0 && exp_miso_q.size() != 0)
         check("miso_byte", {24'b0, got_miso_q.pop_front()}, {24'b0, exp_miso_q.pop_front()});
   end

   task automatic spi_byte(input logic [7:0] tx, input bit chk, input logic [7:0] want, input bit last);
      logic [7:0] rx;
      rx = '0;
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         #(HALF);
         rx[i]    = spi_miso;
         spi_sclk = 1'b1;
         #(HALF);
         if (!(last && i == 0)) spi_sclk = 1'b0;
      end
      if (chk) begin
         exp_miso_q.push_back(want);
         got_miso_q.push_back(rx);
      end
   endtask

   task automatic ss_end();
      #(HALF);
      spi_ss_n = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
      #(4*HALF);
   endtask

   task automatic drain(input string name);
      #(200);
      check({name, "_wr_pending"}, exp_wr_q.size(), 0);
      check({name, "_rd_pending"}, exp_rd_q.size(), 0);
      check({name, "_oe_idle"}, {31'b0, spi_miso_oe}, 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_addr"},  {28'b0, bus.csr_address}, 0);
      check({name, "_read"},  {31'b0, bus.csr_read}, 0);
      check({name, "_write"}, {31'b0, bus.csr_write}, 0);
      check({name, "_wdata"}, bus.csr_writedata, 0);
      check({name, "_miso"},  {31'b0, spi_miso}, 0);
      check({name, "_oe"},    {31'b0, spi_miso_oe}, 0);
   endtask

   initial begin
      reset_n  = 1'b0;
      spi_ss_n = 1'b1;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      irq      = 1'b0;
      #100;
      check_reset_outputs("reset");
      reset_n = 1'b1;
      #200;

      // Single write: 0x85 + 11 22 33 44
      exp_wr_q.push_back('{addr: 4'd5, data: 32'h4433_2211});
      spi_ss_n = 1'b0;
      spi_byte(8'h85, 1, 8'h00, 0);
      check("wr_oe_in_frame", {31'b0, spi_miso_oe}, 1);
      spi_byte(8'h11, 0, 8'h00, 0);
      spi_byte(8'h22, 0, 8'h00, 0);
      spi_byte(8'h33, 0, 8'h00, 0);
      spi_byte(8'h44, 0, 8'h00, 1);
      ss_end();
      drain("write");

      // Read with status: irq=1, cmd 0x03, data A1B2C3D4
      irq = 1'b1;
      exp_rd_q.push_back(4'd3);
      rd_supply_q.push_back(32'hA1B2_C3D4);
      spi_ss_n = 1'b0;
      spi_byte(8'h03, 1, 8'h80, 0);
      irq = 1'b0;
      spi_byte(8'h00, 1, 8'hD4, 0);
      spi_byte(8'h00, 1, 8'hC3, 0);
      spi_byte(8'h00, 1, 8'hB2, 0);
      spi_byte(8'h00, 1, 8'hA1, 1);
      ss_end();
      drain("read");

      // Auto-increment write burst from address 15, wrapping to 0
      exp_wr_q.push_back('{addr: 4'd15, data: 32'h0403_0201});
      exp_wr_q.push_back('{addr: 4'd0,  data: 32'h0807_0605});
      spi_ss_n = 1'b0;
      spi_byte(8'hCF, 1, 8'h00, 0);
      for (int b = 1; b <= 8; b++) spi_byte(8'(b), 0, 8'h00, (b == 8));
      ss_end();
      drain("burst_wr");

      // Non-incrementing read burst at address 2
      exp_rd_q.push_back(4'd2);
      exp_rd_q.push_back(4'd2);
      rd_supply_q.push_back(32'h5A6B_7C8D);
      rd_supply_q.push_back(32'h1122_3344);
      spi_ss_n = 1'b0;
      spi_byte(8'h02, 1, 8'h00, 0);
      spi_byte(8'h00, 1, 8'h8D, 0);
      spi_byte(8'h00, 1, 8'h7C, 0);
      spi_byte(8'h00, 1, 8'h6B, 0);
      spi_byte(8'h00, 1, 8'h5A, 0);
      spi_byte(8'h00, 1, 8'h44, 0);
      spi_byte(8'h00, 1, 8'h33, 0);
      spi_byte(8'h00, 1, 8'h22, 0);
      spi_byte(8'h00, 1, 8'h11, 1);
      ss_end();
      drain("burst_rd");

      // Abort after 3 data bytes of a write
      spi_ss_n = 1'b0;
      spi_byte(8'h81, 0, 8'h00, 0);
      spi_byte(8'hAA, 0, 8'h00, 0);
      spi_byte(8'hBB, 0, 8'h00, 0);
      spi_byte(8'hCC, 0, 8'h00, 0);
      ss_end();
      check("abort_miso", {31'b0, spi_miso}, 0);
      drain("abort");

      // Reset in the middle of a read frame
      exp_rd_q.push_back(4'd4);
      rd_supply_q.push_back(32'hDEAD_BEEF);
      spi_ss_n = 1'b0;
      spi_byte(8'h04, 1, 8'h00, 0);
      spi_byte(8'h00, 1, 8'hEF, 0);
      reset_n = 1'b0;
      #50;
      check_reset_outputs("midreset");
      reset_n = 1'b1;
      #200;
      check("post_reset_oe", {31'b0, spi_miso_oe}, 0);
      spi_byte(8'hFF, 0, 8'h00, 0);
      check("post_reset_oe_sclk", {31'b0, spi_miso_oe}, 0);
      ss_end();
      exp_wr_q.push_back('{addr: 4'd7, data: 32'hDDCC_BBAA});
      spi_ss_n = 1'b0;
      spi_byte(8'h87, 1, 8'h00, 0);
      spi_byte(8'hAA, 0, 8'h00, 0);
      spi_byte(8'hBB, 0, 8'h00, 0);
      spi_byte(8'hCC, 0, 8'h00, 0);
      spi_byte(8'hDD, 0, 8'h00, 1);
      ss_end();
      drain("after_reset");

      #100;
      check("miso_pending", exp_miso_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
